// File: rtl/shift_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_sequencer: command front-end that runs multi-bit shifts as repeated
// one-bit passes through an external registered shift stage. Optional
// SHIFT_FLAGS_EN adds zero/carry flags.  Rev 1.0
// ----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [$clog2(NREG)-1:0] cmd_addr,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_cnt,
  input  logic [DATA_W-1:0]       cmd_data,
  output logic                    enable_sh,
  output logic                    reg_sh,
  output logic [DATA_W-1:0]       reg_sel,
  input  logic [DATA_W-1:0]       shifted_reg,
  output logic                    done,
  output logic [DATA_W-1:0]       result,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  output logic [DATA_W-1:0]       rd_data
`ifdef SHIFT_FLAGS_EN
  ,
  output logic                    flag_z,
  output logic                    flag_c
`endif
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRBK} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bank_q [NREG];
  logic [DATA_W-1:0]   bank_d [NREG];
  logic [DATA_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    steps_q, steps_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                dir_q, dir_d;
  logic [DATA_W-1:0]   result_q, result_d;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    work_d   = work_q;
    steps_d  = steps_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          dir_d   = cmd_dir;
          steps_d = cmd_cnt;
          // A load rides through WRBK as the working value, same as a shift result.
          work_d  = cmd_wr ? cmd_data : bank_q[cmd_addr];
          state_d = (cmd_wr || cmd_cnt == '0) ? WRBK : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        work_d  = shifted_reg;
        steps_d = steps_q - CNT_W'(1);
        state_d = (steps_q > CNT_W'(1)) ? ISSUE : WRBK;
      end
      WRBK: begin
        bank_d[addr_q] = work_q;
        result_d       = work_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      steps_q  <= '0;
      addr_q   <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      steps_q  <= steps_d;
      addr_q   <= addr_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      bank_q   <= bank_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign enable_sh = (state_q == ISSUE);
  assign reg_sh    = dir_q;
  assign reg_sel   = work_q;
  assign done      = (state_q == WRBK);
  // Result is presented during the done pulse and held afterwards.
  assign result    = done ? work_q : result_q;
  assign rd_data   = bank_q[rd_addr];

`ifdef SHIFT_FLAGS_EN
  logic carry_q, carry_d, flag_z_q, flag_z_d, flag_c_q, flag_c_d;

  always_comb begin
    carry_d  = carry_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (state_q == IDLE && cmd_valid) carry_d = 1'b0;
    // Each ISSUE captures the bit about to fall off; the last one wins.
    if (state_q == ISSUE) carry_d = dir_q ? work_q[DATA_W-1] : work_q[0];
    if (state_q == WRBK) begin
      flag_z_d = (work_q == '0);
      flag_c_d = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      carry_q  <= carry_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = done ? (work_q == '0) : flag_z_q;
  assign flag_c = done ? carry_q : flag_c_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// Bench for shift_sequencer: models the one-bit shift stage and scoreboards results.
module tb_shift_sequencer;
  localparam int DATA_W = 4;
  localparam int NREG   = 4;
  localparam int CNT_W  = 3;
  localparam int AW     = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_dir = 1'b0;
  logic [AW-1:0] cmd_addr = '0, rd_addr = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic cmd_ready, enable_sh, reg_sh, done;
  logic [DATA_W-1:0] reg_sel, shifted_reg, result, rd_data;
`ifdef SHIFT_FLAGS_EN
  logic flag_z, flag_c;
`endif

  int errors = 0, checks = 0;
  logic [DATA_W-1:0] model_bank [NREG];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  // Shift stage model: registered, one position per enable_sh.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) shifted_reg <= '0;
    else if (enable_sh) shifted_reg <= reg_sh ? (reg_sel << 1) : (reg_sel >> 1);

  shift_sequencer #(.DATA_W(DATA_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt),
    .cmd_data(cmd_data), .enable_sh(enable_sh), .reg_sh(reg_sh), .reg_sel(reg_sel),
    .shifted_reg(shifted_reg), .done(done), .result(result), .rd_addr(rd_addr),
    .rd_data(rd_data)
`ifdef SHIFT_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compute expected result/carry from the bench's own bank model.
  task automatic model_cmd(input logic wr, input logic [AW-1:0] addr, input logic dir,
                           input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] data,
                           output logic [DATA_W-1:0] res, output logic c);
    logic [DATA_W-1:0] v;
    v = wr ? data : model_bank[addr];
    c = 1'b0;
    if (!wr)
      for (int i = 0; i < int'(cnt); i++) begin
        c = dir ? v[DATA_W-1] : v[0];
        v = dir ? (v << 1) : (v >> 1);
      end
    res = v;
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic dir,
                       input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] data);
    cmd_wr = wr; cmd_addr = addr; cmd_dir = dir; cmd_cnt = cnt; cmd_data = data;
    cmd_valid = 1'b1;
  endtask

  task automatic send(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic dir, input logic [CNT_W-1:0] cnt,
                      input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] res, old, got;
    logic c;
    int cyc, pulses, exp_lat;
    logic prev, b2b;
    model_cmd(wr, addr, dir, cnt, data, res, c);
    exp_q.push_back(res);
    old = model_bank[addr];
    model_bank[addr] = res;
    exp_lat = (wr || cnt == 0) ? 1 : 2 * int'(cnt) + 1;
    check({tag, ".ready"}, cmd_ready, 1);
    drive(wr, addr, dir, cnt, data);
    tick();
    cmd_valid = 1'b0;
    cyc = 1; pulses = 0; prev = 1'b0; b2b = 1'b0;
    while (!done && cyc < 40) begin
      if (enable_sh) pulses++;
      if (enable_sh && prev) b2b = 1'b1;
      prev = enable_sh;
      tick();
      cyc++;
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".pulses"}, pulses, wr ? 0 : int'(cnt));
    check({tag, ".b2b"}, b2b, 0);
    if (exp_q.size() == 0) check({tag, ".sb_empty"}, 1, 0);
    else begin
      got = exp_q.pop_front();
      check({tag, ".result"}, result, got);
    end
`ifdef SHIFT_FLAGS_EN
    check({tag, ".flag_z"}, flag_z, res == '0);
    check({tag, ".flag_c"}, flag_c, c);
`endif
    rd_addr = addr;
    #1;
    check({tag, ".rd_old"}, rd_data, old);
    tick();
    check({tag, ".pulse1"}, done, 0);
    check({tag, ".held"}, result, res);
    check({tag, ".rd_new"}, rd_data, res);
  endtask

  initial begin
    int cyc;
    logic [DATA_W-1:0] r4, got;
    logic c4, bad;
    for (int i = 0; i < NREG; i++) model_bank[i] = '0;

    // Reset state
    #12;
    check("rst.enable_sh", enable_sh, 0);
    check("rst.done", done, 0);
    check("rst.reg_sh", reg_sh, 0);
    check("rst.result", result, 0);
    check("rst.reg_sel", reg_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst.ready", cmd_ready, 1);
    for (int i = 0; i < NREG; i++) begin
      rd_addr = AW'(i);
      #1;
      check("rst.bank", rd_data, 0);
    end

    // Directed cases 1-3
    send("t1.load", 1'b1, 2'd1, 1'b0, 3'd0, 4'b0011);
    send("t1.shl2", 1'b0, 2'd1, 1'b1, 3'd2, 4'b0000);
    send("t2.load", 1'b1, 2'd2, 1'b0, 3'd0, 4'b1001);
    send("t2.shr0", 1'b0, 2'd2, 1'b0, 3'd0, 4'b0000);
    send("t3.load", 1'b1, 2'd0, 1'b0, 3'd0, 4'b1111);
    send("t3.shr7", 1'b0, 2'd0, 1'b0, 3'd7, 4'b0000);
    send("mix.load", 1'b1, 2'd3, 1'b0, 3'd0, 4'b1011);
    send("mix.shr1", 1'b0, 2'd3, 1'b0, 3'd1, 4'b0000);
    send("mix.shl4", 1'b0, 2'd2, 1'b1, 3'd4, 4'b0000);

    // Case 4: valid held through a busy shift of addr1 (1100 >> 3)
    model_cmd(1'b0, 2'd1, 1'b0, 3'd3, 4'b0000, r4, c4);
    exp_q.push_back(r4);
    model_bank[1] = r4;
    drive(1'b0, 2'd1, 1'b0, 3'd3, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 1'b0, 3'd0, 4'b0110);
    cyc = 1; bad = 1'b0;
    while (!done && cyc < 40) begin
      if (cmd_ready) bad = 1'b1;
      tick();
      cyc++;
    end
    check("t4.busy_ready", bad, 0);
    check("t4.latency", cyc, 7);
    check("t4.done_ready", cmd_ready, 0);
    got = exp_q.pop_front();
    check("t4.result", result, got);
    exp_q.push_back(4'b0110);
    model_bank[2] = 4'b0110;
    tick();
    check("t4.after_ready", cmd_ready, 1);
    check("t4.after_done", done, 0);
    tick();
    cmd_valid = 1'b0;
    check("t4.second_done", done, 1);
    got = exp_q.pop_front();
    check("t4.second_result", result, got);
    tick();

    // Case 5: reset during WAIT of a cnt=3 left shift
    send("t5.load", 1'b1, 2'd3, 1'b0, 3'd0, 4'b0101);
    drive(1'b0, 2'd3, 1'b1, 3'd3, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    check("t5.issue", enable_sh, 1);
    tick();
    check("t5.wait", enable_sh, 0);
    rst_n = 1'b0;
    rd_addr = 2'd3;
    #1;
    for (int i = 0; i < NREG; i++) model_bank[i] = '0;
    check("t5.enable_sh", enable_sh, 0);
    check("t5.done", done, 0);
    check("t5.reg_sh", reg_sh, 0);
    check("t5.result", result, 0);
    check("t5.reg_sel", reg_sel, 0);
    check("t5.bank", rd_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) bad = 1'b1;
      tick();
    end
    check("t5.no_done", bad, 0);
    check("t5.ready", cmd_ready, 1);
    send("t5.reuse", 1'b0, 2'd3, 1'b1, 3'd2, 4'b0000);

`ifdef SHIFT_FLAGS_EN
    // Case 6: carry out of the MSB on a single left step
    send("t6.load", 1'b1, 2'd0, 1'b0, 3'd0, 4'b1000);
    send("t6.shl1", 1'b0, 2'd0, 1'b1, 3'd1, 4'b0000);
`endif

    check("sb.empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
